// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with enable, phase resync and
// divisor reload deferred to period boundaries.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  output logic             div_pending,
  output logic [WIDTH-1:0] div_active,
  output logic             div_err,
  output logic             clk_out,
  output logic             clk_out_rising,
  output logic             clk_out_falling,
  output logic [WIDTH-1:0] phase
);

  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  if ((DEFAULT_DIV < 2) ||
      (longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_default
    $error("clock_divider_prog: DEFAULT_DIV out of range 2..2^WIDTH-1");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_cur;
  logic [WIDTH-1:0] pend_div;
  logic             pend;
  logic             err;

  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] half;
  logic             at_end;
  logic             load_ok;
  logic             load_bad;
  logic             apply;

  always_comb begin
    last_cnt = div_cur - WIDTH'(1);
    half     = div_cur >> 1;
    at_end   = (cnt == last_cnt);
    load_ok  = div_load && (div_value >= MIN_DIV);
    load_bad = div_load && (div_value < MIN_DIV);
    // While frozen, a pending divisor does not wait for a period end.
    apply    = pend && (!en || at_end);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt      <= '0;
      div_cur  <= RST_DIV;
      pend_div <= '0;
      pend     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= load_bad;
      if (sync) begin
        cnt <= '0;
        if (load_ok) begin
          div_cur <= div_value;
          pend    <= 1'b0;
        end else if (pend) begin
          div_cur <= pend_div;
          pend    <= 1'b0;
        end
      end else begin
        if (apply) begin
          div_cur <= pend_div;
          cnt     <= '0;
          pend    <= 1'b0;
        end else if (en) begin
          cnt <= at_end ? '0 : cnt + WIDTH'(1);
        end
        // A load coinciding with an apply becomes the next pending value.
        if (load_ok) begin
          pend_div <= div_value;
          pend     <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    clk_out         = (cnt >= half);
    clk_out_rising  = en && (cnt == half);
    clk_out_falling = en && at_end;
  end

  assign phase       = cnt;
  assign div_active  = div_cur;
  assign div_pending = pend;
  assign div_err     = err;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: directed literal checks plus randomized
// stimulus compared every cycle against an arithmetic period model.
module tb_clock_divider_prog;

  localparam int unsigned W    = 16;
  localparam int unsigned DDEF = 4;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] div_value = '0;
  logic         div_load = 1'b0;
  logic         div_pending;
  logic [W-1:0] div_active;
  logic         div_err;
  logic         clk_out;
  logic         clk_out_rising;
  logic         clk_out_falling;
  logic [W-1:0] phase;

  clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DDEF)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync),
    .div_value(div_value), .div_load(div_load),
    .div_pending(div_pending), .div_active(div_active), .div_err(div_err),
    .clk_out(clk_out), .clk_out_rising(clk_out_rising),
    .clk_out_falling(clk_out_falling), .phase(phase)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the period, divisor, pending request.
  int m_ph = 0;
  int m_d = DDEF;
  int m_pdiv = 0;
  bit m_pend = 0;
  bit m_err = 0;
  bit m_ok;

  always @(posedge clk_in) begin
    m_ok = div_load && (int'(div_value) >= 2);
    if (rst) begin
      m_ph = 0; m_d = DDEF; m_pdiv = 0; m_pend = 0; m_err = 0;
    end else begin
      m_err = div_load && (int'(div_value) < 2);
      if (sync) begin
        m_ph = 0;
        if (m_ok) begin
          m_d = int'(div_value); m_pend = 0;
        end else if (m_pend) begin
          m_d = m_pdiv; m_pend = 0;
        end
      end else begin
        if (m_pend && (!en || m_ph == m_d - 1)) begin
          m_d = m_pdiv; m_ph = 0; m_pend = 0;
        end else if (en) begin
          m_ph = (m_ph + 1) % m_d;
        end
        if (m_ok) begin
          m_pdiv = int'(div_value); m_pend = 1;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (cmp_on) begin
      chk("m_phase",   phase, m_ph);
      chk("m_active",  div_active, m_d);
      chk("m_pending", div_pending, m_pend);
      chk("m_err",     div_err, m_err);
      chk("m_clk",     clk_out, (m_ph >= m_d / 2));
      chk("m_rise",    clk_out_rising, en && (m_ph == m_d / 2));
      chk("m_fall",    clk_out_falling, en && (m_ph == m_d - 1));
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_ctl();
    sync = 1'b0; div_load = 1'b0; div_value = '0;
  endtask

  initial begin
    int exp_ph;
    cyc(); cyc();
    rst = 1'b0;
    cmp_on = 1'b1;
    chk("rst_phase", phase, 0);
    chk("rst_active", div_active, 4);
    chk("rst_clk", clk_out, 0);
    chk("rst_pending", div_pending, 0);

    // Default divisor 4
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp_ph = (i + 1) % 4;
      chk("d4_phase", phase, exp_ph);
      chk("d4_clk", clk_out, exp_ph >= 2);
      chk("d4_rise", clk_out_rising, exp_ph == 2);
      chk("d4_fall", clk_out_falling, exp_ph == 3);
    end

    // Odd divisor loaded mid-period
    cyc();
    chk("odd_ph1", phase, 1);
    div_load = 1'b1; div_value = W'(5);
    cyc();
    clear_ctl();
    chk("odd_pend_a", div_pending, 1);
    chk("odd_act_a", div_active, 4);
    cyc();
    chk("odd_pend_b", div_pending, 1);
    chk("odd_ph3", phase, 3);
    cyc();
    chk("odd_pend_c", div_pending, 0);
    chk("odd_act_c", div_active, 5);
    chk("odd_ph0", phase, 0);
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk("d5_clk", clk_out, i >= 2);
      chk("d5_rise", clk_out_rising, i == 2);
      chk("d5_fall", clk_out_falling, i == 4);
    end

    // D=2 via sync with direct load
    sync = 1'b1; div_load = 1'b1; div_value = W'(2);
    cyc();
    clear_ctl();
    chk("d2_act", div_active, 2);
    chk("d2_ph0_clk", clk_out, 0);
    cyc();
    chk("d2_clk1", clk_out, 1);
    chk("d2_rise", clk_out_rising, 1);
    chk("d2_fall", clk_out_falling, 1);
    cyc();
    chk("d2_clk0", clk_out, 0);

    // Illegal load at D=4
    sync = 1'b1; div_load = 1'b1; div_value = W'(4);
    cyc();
    div_load = 1'b1; div_value = W'(1); sync = 1'b0;
    cyc();
    clear_ctl();
    chk("bad_err", div_err, 1);
    chk("bad_pend", div_pending, 0);
    chk("bad_act", div_active, 4);
    chk("bad_phase", phase, 1);
    cyc();
    chk("bad_err_gone", div_err, 0);

    // Freeze and resync at D=6
    sync = 1'b1; div_load = 1'b1; div_value = W'(6);
    cyc();
    clear_ctl();
    repeat (4) cyc();
    chk("frz_ph4", phase, 4);
    en = 1'b0;
    cyc(); cyc();
    chk("frz_hold", phase, 4);
    chk("frz_clk", clk_out, 1);
    chk("frz_rise", clk_out_rising, 0);
    chk("frz_fall", clk_out_falling, 0);
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("frz_sync_ph", phase, 0);
    chk("frz_sync_clk", clk_out, 0);
    en = 1'b1;
    cyc();
    chk("frz_resume", phase, 1);

    // Collisions
    sync = 1'b1; div_load = 1'b1; div_value = W'(7);
    cyc();
    clear_ctl();
    chk("col_act", div_active, 7);
    chk("col_ph", phase, 0);
    chk("col_pend", div_pending, 0);
    cyc();
    div_load = 1'b1; div_value = W'(3);
    cyc();
    clear_ctl();
    chk("col_pend3", div_pending, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("col_rst_act", div_active, 4);
    chk("col_rst_ph", phase, 0);
    chk("col_rst_pend", div_pending, 0);
    chk("col_rst_clk", clk_out, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      en        = ($urandom_range(0, 99) < 85);
      sync      = ($urandom_range(0, 99) < 3);
      div_load  = ($urandom_range(0, 99) < 8);
      div_value = W'($urandom_range(0, 12));
      cyc();
    end
    rst = 1'b0; en = 1'b0; clear_ctl();
    cyc();
    cmp_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable integer clock divider. Successor to the power-of-two divider: same clk_out / rising / falling strobe semantics, but with any divisor D from 2 to 2^WIDTH-1.
- Adds enable, phase resync, and glitch-free divisor reload at period boundaries.
- Drives clock-enable strobes for pixel, frame and audio timing from one system clock.

Parameters:
- WIDTH, 16: width of the divisor and of the phase counter.
- DEFAULT_DIV, 4: divisor active after reset. Legal range is 2..2^WIDTH-1; any other value is an elaboration error.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable. Low freezes all state.
- sync  in  1  restart the period at phase 0.
- div_value  in  WIDTH  requested divisor.
- div_load  in  1  one-cycle strobe that captures div_value.
- div_pending  out  1  a captured divisor is waiting for a period boundary.
- div_active  out  WIDTH  divisor D currently in use.
- div_err  out  1  one-cycle pulse: div_load rejected (div_value < 2).
- clk_out  out  1  divided clock, low phase first.
- clk_out_rising  out  1  strobe in the first cycle clk_out is high.
- clk_out_falling  out  1  strobe in the last cycle clk_out is high.
- phase  out  WIDTH  current count within the period, 0..D-1.

Behaviour:
- Definitions: D = div_active; L = floor(D/2).
- Phase counter cnt (WIDTH bits) steps 0..D-1 and then wraps to 0.
- clk_out = (cnt >= L): low for L cycles, high for D-L cycles. Odd D gives the extra cycle to the high phase.
- clk_out_rising = en & (cnt == L).
- clk_out_falling = en & (cnt == D-1).
- For D=2 both strobes assert in the same cycle (cnt=1).
- clk_out and phase are decoded from registers only; no combinational path from any input.
- Reset (rst=1 at clk_in edge):
  - cnt=0, div_active=DEFAULT_DIV, pending flag and pending register cleared, div_err=0.
  - Hence clk_out=0 and both strobes 0.
  - rst overrides every other input.
- en=1: cnt <= (cnt==D-1) ? 0 : cnt+1.
- en=0:
  - cnt, clk_out and div_active hold; both strobes forced 0.
  - div_load is still captured.
  - A pending divisor is applied on the next clk_in edge, with cnt <= 0.
- div_load with div_value >= 2:
  - pending_div <= div_value; div_pending=1 from the next cycle.
  - A second load while pending overwrites the pending value (last write wins).
- div_load with div_value < 2: ignored, pending state unchanged, div_err=1 for exactly the next cycle.
- Apply point is the cycle with en=1 and cnt==D-1 while pending: div_active <= pending_div, cnt <= 0, div_pending <= 0. The new period starts cleanly, so no runt pulse.
- div_load in the same cycle as the apply point:
  - The old pending value is applied.
  - The new value becomes pending.
- sync=1 (and rst=0):
  - cnt <= 0 regardless of en.
  - If pending, div_active <= pending_div and pending clears.
  - If div_load also asserts that cycle, the new div_value (when >= 2) is applied directly and pending ends 0.
- Priority: rst > sync > apply point > count.
- Divisor change never produces a high or low phase shorter than min(old L, new L) cycles.
- Arithmetic: cnt compared against D-1 computed at WIDTH bits; no overflow because D <= 2^WIDTH-1.

Decomposition:
- No shared package needed. Constants MIN_DIV=2 and the WIDTH-bit helpers stay local.
- Single module; no sub-module.
- Strobe decode is a small always-comb section; the counter/reload logic is one sequential block.

Test Plan:
- Reset, then 8 cycles en=1, DEFAULT_DIV=4:
  - phase 0,1,2,3,0,1,2,3; clk_out 0,0,1,1 repeating.
  - rising at phase 2, falling at phase 3.
  - div_active=4.
- Odd divisor: div_load div_value=5 at phase 1 of a D=4 period:
  - div_pending=1 until the phase-3 edge.
  - Next period D=5, clk_out 0,0,1,1,1; rising at phase 2, falling at phase 4.
- D=2: clk_out toggles every cycle; rising and falling both high when phase=1.
- Illegal load: div_load div_value=1 at D=4:
  - div_err pulses one cycle; div_pending stays 0; div_active=4; waveform unchanged.
- Freeze and resync, D=6:
  - en=0 at phase 4: phase holds 4, clk_out holds 1, strobes 0.
  - sync=1 while en=0: phase=0, clk_out=0.
  - en=1 resumes at phase 1.
- Collision:
  - sync and div_load(7) in the same cycle: div_active=7 next cycle, phase=0, div_pending=0.
  - rst asserted mid-period with a pending divisor: all outputs return to reset values; div_active=DEFAULT_DIV.
